// File: rtl/ram_master.sv
// rtl/ram_master.sv - request-driven SRAM master on a shared tri-state bus; RAM_MASTER_VERIFY_EN adds write read-back verify
module ram_master #(
    parameter int BYTE_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [BYTE_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [BYTE_W-1:0] rsp_rdata,
    output logic              err,
    output logic [ADDR_W-1:0] address,
    output logic              r_e,
    output logic              w_e,
    inout  wire  [BYTE_W-1:0] mem_bus
);

`ifdef RAM_MASTER_VERIFY_EN
    typedef enum logic [2:0] {IDLE, WR, RD1, RD2, VR1, VR2} state_t;
`else
    typedef enum logic [1:0] {IDLE, WR, RD1, RD2} state_t;
`endif

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BYTE_W-1:0]   wdata_q, wdata_d;
    logic                ready_q, ready_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic                r_e_q, r_e_d;
    logic                w_e_q, w_e_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [BYTE_W-1:0]   rsp_rdata_q, rsp_rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            ready_q     <= 1'b0;
            address_q   <= '0;
            r_e_q       <= 1'b0;
            w_e_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            ready_q     <= ready_d;
            address_q   <= address_d;
            r_e_q       <= r_e_d;
            w_e_q       <= w_e_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = req_we ? WR : RD1;
                end
            end
`ifdef RAM_MASTER_VERIFY_EN
            WR:  state_d = VR1;
            VR1: state_d = VR2;
            VR2: state_d = IDLE;
`else
            WR:  state_d = IDLE;
`endif
            RD1: state_d = RD2;
            RD2: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Memory strobes come from the next state so they toggle only on clock edges.
    always_comb begin
        ready_d     = (state_d == IDLE);
        w_e_d       = (state_d == WR);
        r_e_d       = (state_d == RD1) || (state_d == RD2);
`ifdef RAM_MASTER_VERIFY_EN
        r_e_d       = r_e_d || (state_d == VR1) || (state_d == VR2);
`endif
        address_d   = (state_d != IDLE) ? addr_d : address_q;
        rsp_valid_d = (state_q == RD2);
        rsp_rdata_d = (state_q == RD2) ? mem_bus : rsp_rdata_q;
    end

`ifdef RAM_MASTER_VERIFY_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (state_q == VR2 && mem_bus != wdata_q)
            err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign req_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign address   = address_q;
    assign r_e       = r_e_q;
    assign w_e       = w_e_q;
    assign mem_bus   = w_e_q ? wdata_q : {BYTE_W{1'bz}};

endmodule

// File: tb/tb_ram_master.sv
// tb/tb_ram_master.sv - randomized self-checking bench for ram_master against a memory-array reference model
module tb_ram_master;
    localparam int BW = 8;
    localparam int AW = 8;
    localparam logic [BW-1:0] BG = 8'h3C;

    logic          clk, rst;
    logic          req_valid, req_we;
    logic [AW-1:0] req_addr;
    logic [BW-1:0] req_wdata;
    logic          req_ready, rsp_valid, err, r_e, w_e;
    logic [BW-1:0] rsp_rdata;
    logic [AW-1:0] address;
    wire  [BW-1:0] mem_bus;

    logic [BW-1:0] tb_ram  [0:(1<<AW)-1];
    logic [BW-1:0] ref_mem [0:(1<<AW)-1];
    logic          ovr_en;
    logic [BW-1:0] ovr_val;
    logic [BW-1:0] rdata_exp;
    logic          err_exp;
    int            tests, fails;

    ram_master #(.BYTE_W(BW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .err(err),
        .address(address), .r_e(r_e), .w_e(w_e), .mem_bus(mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory device plus a background keeper value whenever the master should not drive.
    assign mem_bus = ovr_en ? ovr_val : (w_e ? {BW{1'bz}} : (r_e ? tb_ram[address] : BG));

    always @(posedge clk) if (w_e) tb_ram[address] <= mem_bus;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("re_we_exclusive", 32'(r_e & w_e), 32'd0);
            if (!w_e && !r_e && !ovr_en) chk("bus_idle_hiz", 32'(mem_bus), 32'(BG));
        end
    end

    task automatic scramble();
        req_valid = 1'b1;
        req_we    = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = BW'($urandom);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [BW-1:0] d, input bit bad);
        req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
        chk("wr_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        scramble();
        chk("wr_we", 32'(w_e), 32'd1);
        chk("wr_re", 32'(r_e), 32'd0);
        chk("wr_addr", 32'(address), 32'(a));
        chk("wr_bus", 32'(mem_bus), 32'(d));
        chk("wr_busy", 32'(req_ready), 32'd0);
        ref_mem[a] = d;
`ifdef RAM_MASTER_VERIFY_EN
        @(negedge clk);
        chk("vr1_re", 32'(r_e), 32'd1);
        chk("vr1_addr", 32'(address), 32'(a));
        @(negedge clk);
        chk("vr2_re", 32'(r_e), 32'd1);
        if (bad) begin ovr_en = 1'b1; ovr_val = ~d; err_exp = 1'b1; end
        @(negedge clk);
        ovr_en = 1'b0;
`else
        if (bad) err_exp = 1'b0;
        @(negedge clk);
`endif
        req_valid = 1'b0;
        chk("wr_done_ready", 32'(req_ready), 32'd1);
        chk("wr_done_we", 32'(w_e), 32'd0);
        chk("wr_no_rsp", 32'(rsp_valid), 32'd0);
        chk("wr_rdata_hold", 32'(rsp_rdata), 32'(rdata_exp));
        chk("err", 32'(err), 32'(err_exp));
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = BW'($urandom);
        chk("rd_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        scramble();
        chk("rd1_re", 32'(r_e), 32'd1);
        chk("rd1_we", 32'(w_e), 32'd0);
        chk("rd1_addr", 32'(address), 32'(a));
        chk("rd1_rsp", 32'(rsp_valid), 32'd0);
        chk("rd1_bus", 32'(mem_bus), 32'(ref_mem[a]));
        @(negedge clk);
        chk("rd2_re", 32'(r_e), 32'd1);
        chk("rd2_addr", 32'(address), 32'(a));
        chk("rd2_rsp", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        rdata_exp = ref_mem[a];
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_rdata", 32'(rsp_rdata), 32'(rdata_exp));
        chk("rsp_ready", 32'(req_ready), 32'd1);
        chk("rsp_re_off", 32'(r_e), 32'd0);
        chk("rsp_addr_hold", 32'(address), 32'(a));
    endtask

    initial begin
        tests = 0; fails = 0;
        ovr_en = 1'b0; ovr_val = '0;
        rdata_exp = '0; err_exp = 1'b0;
        for (int i = 0; i < (1 << AW); i++) begin tb_ram[i] = '0; ref_mem[i] = '0; end
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        #2;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_re", 32'(r_e), 32'd0);
        chk("rst_we", 32'(w_e), 32'd0);
        chk("rst_addr", 32'(address), 32'd0);
        chk("rst_rsp", 32'(rsp_valid), 32'd0);
        chk("rst_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_bus", 32'(mem_bus), 32'(BG));
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        do_write(8'h12, 8'hA5, 1'b0);
        do_read(8'h12);

        for (int i = 0; i < 6; i++) do_write(AW'(i), BW'(8'h10 + i), 1'b0);
        for (int i = 0; i < 6; i++) do_read(AW'(i));

        do_write(8'hFF, 8'h77, 1'b0);
        do_write(8'h00, 8'h88, 1'b0);
        do_read(8'hFF);
        do_read(8'h00);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 1) == 0) do_write(AW'($urandom), BW'($urandom), 1'b0);
            else                           do_read(AW'($urandom_range(0, 7)));
        end

        do_write(8'h34, 8'h5E, 1'b0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h34;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("abort_rd2_re", 32'(r_e), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("abort_re", 32'(r_e), 32'd0);
        chk("abort_addr", 32'(address), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        chk("abort_rdata", 32'(rsp_rdata), 32'd0);
        rdata_exp = '0; err_exp = 1'b0;
        @(negedge clk);
        chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_back", 32'(req_ready), 32'd1);
        chk("abort_no_rsp2", 32'(rsp_valid), 32'd0);
        chk("abort_no_access", 32'(r_e | w_e), 32'd0);
        do_read(8'h34);

        do_write(8'h40, 8'hFF, 1'b1);
        do_write(8'h41, 8'h11, 1'b0);
        do_write(8'h42, 8'h22, 1'b0);
        do_read(8'h41);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
